// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MIPS data-memory path: access-controller FSM
// encoding, main-opcode constants also decoded by the control unit, and the
// default bus timeout.
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam int DEFAULT_TIMEOUT = 16;

    // True when a byte address does not point at the start of a 32-bit word.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_access_ctrl_if.sv
// External data-memory bus: a held request with a one-cycle completion strobe.
// The controller drives the master side, the memory drives the slave side.
interface dmem_access_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/dmem_timeout_cnt.sv
// Wait-cycle counter for the access controller. Cleared when an access is
// accepted, advanced on every BUSY cycle without an ack; tc flags the last
// BUSY cycle allowed before the access is aborted.
module dmem_timeout_cnt #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

    logic [W-1:0] count_q;

    // Counter register: clear has priority, saturates at the terminal value.
    // NOTE: state is updated with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en && (count_q != LAST)) begin
            count_q <= count_q + W'(1);
        end
    end

    assign tc = (count_q == LAST);

endmodule

// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the single-cycle MIPS datapath.
// Accepts lw/sw from the control unit, runs one req/ack transaction on the
// data-memory bus, stalls the core until it retires and returns load data.
// Optional build macro MISALIGN_CHK_EN: unaligned accesses are rejected in
// IDLE with an err pulse and never reach the bus. Without it the low two
// address bits are dropped and the enclosing word is accessed.
module dmem_access_ctrl
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              stall,
    output logic              err,
    dmem_access_ctrl_if.master bus
);

    state_t            state_q;
    state_t            state_d;
    logic              req_any;
    logic              misalign;
    logic              cnt_clr;
    logic              cnt_en;
    logic              cnt_tc;
    logic              req_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    assign req_any = mem_read | mem_write;

`ifdef MISALIGN_CHK_EN
    assign misalign = req_any && is_misaligned(addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    dmem_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (cnt_tc)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and wait-counter control.
    // NOTE: every signal gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_any) begin
                    cnt_clr = 1'b1;
                    state_d = misalign ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (bus.ack || cnt_tc) begin
                    state_d = DONE;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch, bus drive registers, load-data and error outputs.
    // Aborted loads return zero; stores never touch rdata, even on abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            req_q <= (state_d == BUSY);
            err   <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req_any) begin
                        we_q    <= mem_write;
                        addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                        wdata_q <= wdata;
                        if (misalign) begin
                            err <= 1'b1;
                            if (!mem_write) rdata <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (bus.ack) begin
                        if (!we_q) rdata <= bus.rdata;
                    end else if (cnt_tc) begin
                        err <= 1'b1;
                        if (!we_q) rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stall = ((state_q == IDLE) && req_any) || (state_q == BUSY);

    assign bus.req   = req_q;
    assign bus.we    = we_q;
    assign bus.addr  = addr_q;
    assign bus.wdata = wdata_q;

endmodule
